// File: rtl/result_packer_pkg.sv
// Shared constants, element record and symmetric index table for result_packer.
// The table is only referenced when RESULT_PACKER_CHECK_EN is defined.
package result_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int MAT_N      = 4;
  localparam int N_ELEM     = MAT_N * MAT_N;
  localparam int N_COEF     = 10;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [1:0]            row;
    logic [1:0]            col;
    logic                  last;
  } elem_t;

  typedef logic [3:0] idx_t;

  // Coefficient index expected at each element position, row-major.
  function automatic idx_t sym_idx(input logic [3:0] cnt);
    idx_t r;
    unique case (cnt)
      4'd0:         r = 4'd1;
      4'd1, 4'd4:   r = 4'd2;
      4'd2, 4'd8:   r = 4'd3;
      4'd3, 4'd12:  r = 4'd4;
      4'd5:         r = 4'd5;
      4'd6, 4'd9:   r = 4'd6;
      4'd7, 4'd13:  r = 4'd7;
      4'd10:        r = 4'd8;
      4'd11, 4'd14: r = 4'd9;
      4'd15:        r = 4'd10;
      default:      r = 4'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/result_packer_if.sv
// Output element stream of result_packer (valid/ready).
interface result_packer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_row;
  logic [1:0]        out_col;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data, out_row, out_col,
    output out_last, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_row, out_col,
    input  out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/result_packer_fifo.sv
// Element buffer for result_packer; a full push is taken only alongside a pop.
// Head reads as zero while empty.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/result_packer.sv
// Packs controller coefficient beats into a tagged 4x4 element stream.
// Define RESULT_PACKER_CHECK_EN to flag out-of-sequence selects on seq_err.
module result_packer
  import result_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     output_rdy,
  input  logic [3:0]               output_sel,
  input  logic [N_COEF*DATA_W-1:0] b_bus,
  result_packer_if.master          o,
  output logic                     overflow,
  output logic                     seq_err
);
  localparam int EW = DATA_W + $bits(elem_t) - DATA_W_DEF;

  logic              beat_q;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] cap;
  logic [EW-1:0]     din;
  logic [EW-1:0]     dout;
  logic              full;
  logic              empty;
  logic              pop;

  always_comb begin
    cap = '0;
    for (int k = 1; k <= N_COEF; k++) begin
      if (output_sel == 4'(k))
        cap = b_bus[(k-1)*DATA_W +: DATA_W];
    end
  end

  // cnt already splits as {row, col}
  assign din = {cap, cnt, (cnt == 4'hF)};
  assign pop = !empty && o.out_ready;

  result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .reset (reset),
    .push  (beat_q),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign o.out_valid = !empty;
  assign {o.out_data, o.out_row,
          o.out_col, o.out_last} = dout;

  always_ff @(posedge CLK) begin
    if (reset) begin
      beat_q   <= 1'b0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      beat_q <= output_rdy;
      if (beat_q) begin
        cnt <= cnt + 1'b1;
        if (full && !pop) overflow <= 1'b1;
      end
    end
  end

`ifdef RESULT_PACKER_CHECK_EN
  always_ff @(posedge CLK) begin
    if (reset)
      seq_err <= 1'b0;
    else if (beat_q && output_sel != sym_idx(cnt))
      seq_err <= 1'b1;
  end
`else
  assign seq_err = 1'b0;
`endif
endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: vector table, corner sequences,
// and random traffic against a queue-based model.
module tb_result_packer;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
`ifdef RESULT_PACKER_CHECK_EN
  localparam bit SERR_EN = 1'b1;
`else
  localparam bit SERR_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             output_rdy = 1'b0;
  logic [3:0]       output_sel = '0;
  logic [10*DW-1:0] b_bus = '0;
  logic             overflow;
  logic             seq_err;

  result_packer_if #(.DATA_W(DW)) ifc ();

  result_packer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .output_rdy (output_rdy),
    .output_sel (output_sel),
    .b_bus      (b_bus),
    .o          (ifc),
    .overflow   (overflow),
    .seq_err    (seq_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [1:0]    c;
    logic          l;
  } ent_t;

  typedef struct {
    logic [3:0]    sel;
    logic [DW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          last;
  } vec_t;

  ent_t q[$];
  int   m_cnt;
  bit   m_pend;
  bit   m_ovf;
  bit   m_serr;
  int   total = 0;
  int   bad = 0;

  // Upper-triangle numbering of a symmetric 4x4 matrix, 1-based.
  function automatic int sym(int r, int c);
    int i = (r < c) ? r : c;
    int j = (r < c) ? c : r;
    return i * 4 - i * (i - 1) / 2 + (j - i) + 1;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic model(bit rdy, logic [3:0] sel, bit ord, bit rst);
    bit   popping;
    bit   was_full;
    ent_t e;
    if (rst) begin
      q.delete();
      m_cnt  = 0;
      m_pend = 0;
      m_ovf  = 0;
      m_serr = 0;
      return;
    end
    popping  = (q.size() > 0) && ord;
    was_full = (q.size() == DEPTH);
    if (popping) void'(q.pop_front());
    if (m_pend) begin
      e.d = '0;
      if (sel >= 1 && sel <= 10)
        e.d = b_bus[(int'(sel) - 1) * DW +: DW];
      e.r = 2'(m_cnt / 4);
      e.c = 2'(m_cnt % 4);
      e.l = (m_cnt == 15);
      if (!was_full || popping) q.push_back(e);
      else m_ovf = 1;
      if (SERR_EN && int'(sel) != sym(m_cnt / 4, m_cnt % 4))
        m_serr = 1;
      m_cnt = (m_cnt + 1) % 16;
    end
    m_pend = rdy;
  endtask

  task automatic compare_all();
    chk("valid", ifc.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("data", ifc.out_data, q[0].d);
      chk("row", ifc.out_row, q[0].r);
      chk("col", ifc.out_col, q[0].c);
      chk("last", ifc.out_last, q[0].l);
    end else begin
      chk("data0", ifc.out_data, 0);
      chk("pos0", {ifc.out_row, ifc.out_col, ifc.out_last}, 0);
    end
    chk("overflow", overflow, m_ovf);
    chk("seq_err", seq_err, m_serr);
  endtask

  task automatic step(bit rdy, logic [3:0] sel, bit ord, bit rst);
    output_rdy    = rdy;
    output_sel    = sel;
    ifc.out_ready = ord;
    reset         = rst;
    @(posedge CLK);
    model(rdy, sel, ord, rst);
    #1;
    compare_all();
  endtask

  task automatic beat(logic [3:0] sel, bit ord);
    step(1'b1, 4'd0, ord, 1'b0);
    step(1'b0, sel, ord, 1'b0);
  endtask

  task automatic frame_b();
    for (int k = 1; k <= 10; k++)
      b_bus[(k-1)*DW +: DW] = 16'(k * 'h11);
  endtask

  logic [3:0]    t_sel [16] = '{1, 2, 3, 4, 2, 5, 6, 7,
                                3, 6, 8, 9, 4, 7, 9, 10};
  logic [DW-1:0] t_dat [16] = '{'h11, 'h22, 'h33, 'h44,
                                'h22, 'h55, 'h66, 'h77,
                                'h33, 'h66, 'h88, 'h99,
                                'h44, 'h77, 'h99, 'hAA};
  vec_t vec [16];

  initial begin
    for (int i = 0; i < 16; i++)
      vec[i] = '{t_sel[i], t_dat[i], 2'(i / 4), 2'(i % 4), i == 15};
    ifc.out_ready = 1'b0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", ifc.out_valid, 0);
    chk("rst_data", ifc.out_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_serr", seq_err, 0);

    frame_b();
    for (int i = 0; i < 16; i++) begin
      beat(vec[i].sel, 1'b1);
      chk("frm_data", ifc.out_data, vec[i].data);
      chk("frm_row", ifc.out_row, vec[i].row);
      chk("frm_col", ifc.out_col, vec[i].col);
      chk("frm_last", ifc.out_last, vec[i].last);
    end
    step(0, 0, 1, 0);
    chk("frm_drain", ifc.out_valid, 0);

    step(0, 0, 0, 1);
    beat(1, 0);
    beat(2, 0);
    beat(3, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("bp_valid", ifc.out_valid, 1);
      chk("bp_hold", ifc.out_data, 'h11);
      chk("bp_ovf", overflow, 0);
    end
    step(0, 0, 1, 0);
    chk("bp_drain1", ifc.out_data, 'h22);
    step(0, 0, 1, 0);
    chk("bp_drain2", ifc.out_data, 'h33);
    step(0, 0, 1, 0);
    chk("bp_empty", ifc.out_valid, 0);

    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) beat(t_sel[i], 0);
    chk("ov_flag", overflow, 1);
    chk("ov_head", ifc.out_data, 'h11);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("ov_empty", ifc.out_valid, 0);
    chk("ov_sticky", overflow, 1);
    beat(5, 1);
    chk("ov_skip", {ifc.out_row, ifc.out_col}, 4'b0101);
    chk("ov_data", ifc.out_data, 'h55);

    step(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) beat(t_sel[i], 0);
    step(1, 0, 0, 0);
    step(0, 2, 1, 0);
    chk("fp_ovf", overflow, 0);
    chk("fp_head", ifc.out_data, 'h22);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("fp_empty", ifc.out_valid, 0);

    step(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) beat(t_sel[i], 1);
    step(1, 0, 0, 0);
    step(0, t_sel[7], 0, 1);
    chk("mr_valid", ifc.out_valid, 0);
    chk("mr_data", ifc.out_data, 0);
    step(0, 0, 0, 0);
    chk("mr_nopend", ifc.out_valid, 0);
    beat(1, 1);
    chk("mr_pos", {ifc.out_row, ifc.out_col}, 0);
    chk("mr_data2", ifc.out_data, 'h11);

    step(0, 0, 0, 1);
    beat(1, 1);
    beat(5, 1);
    chk("seq_flag", seq_err, SERR_EN);

    step(0, 0, 0, 1);
    for (int n = 0; n < 600; n++) begin
      logic [3:0] s;
      for (int k = 0; k < 10; k++)
        b_bus[k*DW +: DW] = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        s = 4'(sym(m_cnt / 4, m_cnt % 4));
      else
        s = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7, s,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
